// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared types and constants for the cpu sequencer
package cpu_pkg;

   localparam int DATA_W = 8;

   // FSM state encoding
   typedef enum logic [2:0] {
      ST_IDLE      = 3'd0,
      ST_FETCH     = 3'd1,
      ST_EXEC      = 3'd2,
      ST_FETCH_IMM = 3'd3,
      ST_HALTED    = 3'd4
   } state_t;

   // Instruction byte: [7:4] cmd, [3:0] op; unlisted cmds behave as NOP
   localparam logic [3:0] CMD_EXEC = 4'h0;
   localparam logic [3:0] CMD_LDI  = 4'h1;
   localparam logic [3:0] CMD_HALT = 4'hF;

   // States in which a program fetch is outstanding
   function automatic logic is_fetch(input state_t s);
      return (s == ST_FETCH) || (s == ST_FETCH_IMM);
   endfunction

endpackage

// File: rtl/cpu_comb.sv
// rtl/cpu_comb.sv - combinational datapath operating on registers A-D and carry
module cpu_comb (
   input  logic [7:0] Ain,
   input  logic [7:0] Bin,
   input  logic [7:0] Cin,
   input  logic [7:0] Din,
   input  logic       Carryin,
   input  logic [3:0] op,
   output logic [7:0] Aout,
   output logic [7:0] Bout,
   output logic [7:0] Cout,
   output logic [7:0] Dout,
   output logic       Carryout
);

   // op selects an ALU function; registers not touched by op pass through
   always_comb begin
      Aout     = Ain;
      Bout     = Bin;
      Cout     = Cin;
      Dout     = Din;
      Carryout = Carryin;
      case (op)
         4'h0: {Carryout, Aout} = {1'b0, Ain} + {1'b0, Bin} + {8'd0, Carryin};
         4'h1: {Carryout, Aout} = {1'b0, Ain} - {1'b0, Bin} - {8'd0, Carryin};
         4'h2: Aout = Ain & Bin;
         4'h3: Aout = Ain | Bin;
         4'h4: Aout = Ain ^ Bin;
         4'h5: {Carryout, Aout} = {Ain, Carryin};
         4'h6: {Aout, Carryout} = {Carryin, Ain};
         4'h7: begin
            Aout = Bin;
            Bout = Ain;
         end
         default: ;
      endcase
   end

endmodule

// File: rtl/cpu_seq.sv
// rtl/cpu_seq.sv - fetch/execute sequencer and register file around cpu_comb
module cpu_seq
   import cpu_pkg::*;
#(
   parameter logic [7:0] RESET_PC = 8'h00
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       start,
   output logic       prog_req,
   output logic [7:0] prog_addr,
   input  logic       prog_ack,
   input  logic [7:0] prog_data,
   output logic       busy,
   output logic       halted,
   output logic [7:0] reg_a,
   output logic [7:0] reg_b,
   output logic [7:0] reg_c,
   output logic [7:0] reg_d,
   output logic       carry,
   output logic [7:0] pc
);

   state_t              state_q, state_d;
   logic [DATA_W-1:0]   pc_q, pc_d;
   logic [DATA_W-1:0]   ir_q, ir_d;
   logic [DATA_W-1:0]   reg_a_q, reg_a_d, reg_b_q, reg_b_d;
   logic [DATA_W-1:0]   reg_c_q, reg_c_d, reg_d_q, reg_d_d;
   logic                carry_q, carry_d;
   logic                prog_req_q, prog_req_d;
   logic                busy_q, busy_d;
   logic                halted_q, halted_d;

   logic [DATA_W-1:0]   alu_a, alu_b, alu_c, alu_d;
   logic                alu_carry;

   cpu_comb u_comb (
      .Ain      (reg_a_q),
      .Bin      (reg_b_q),
      .Cin      (reg_c_q),
      .Din      (reg_d_q),
      .Carryin  (carry_q),
      .op       (ir_q[3:0]),
      .Aout     (alu_a),
      .Bout     (alu_b),
      .Cout     (alu_c),
      .Dout     (alu_d),
      .Carryout (alu_carry)
   );

   // Next-state, PC and register-file update; status outputs follow the next state
   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      ir_d    = ir_q;
      reg_a_d = reg_a_q;
      reg_b_d = reg_b_q;
      reg_c_d = reg_c_q;
      reg_d_d = reg_d_q;
      carry_d = carry_q;
      case (state_q)
         ST_IDLE, ST_HALTED: begin
            if (start) begin
               state_d = ST_FETCH;
               pc_d    = RESET_PC;
            end
         end
         ST_FETCH: begin
            if (prog_ack) begin
               ir_d    = prog_data;
               pc_d    = pc_q + 8'd1;
               state_d = ST_EXEC;
            end
         end
         ST_EXEC: begin
            case (ir_q[7:4])
               CMD_EXEC: begin
                  reg_a_d = alu_a;
                  reg_b_d = alu_b;
                  reg_c_d = alu_c;
                  reg_d_d = alu_d;
                  carry_d = alu_carry;
                  state_d = ST_FETCH;
               end
               CMD_LDI:  state_d = ST_FETCH_IMM;
               CMD_HALT: state_d = ST_HALTED;
               default:  state_d = ST_FETCH;
            endcase
         end
         ST_FETCH_IMM: begin
            if (prog_ack) begin
               case (ir_q[1:0])
                  2'd0:    reg_a_d = prog_data;
                  2'd1:    reg_b_d = prog_data;
                  2'd2:    reg_c_d = prog_data;
                  default: reg_d_d = prog_data;
               endcase
               pc_d    = pc_q + 8'd1;
               state_d = ST_FETCH;
            end
         end
         default: state_d = ST_IDLE;
      endcase
      prog_req_d = is_fetch(state_d);
      busy_d     = is_fetch(state_d) || (state_d == ST_EXEC);
      halted_d   = (state_d == ST_HALTED);
   end

   // State and architectural registers; reset aborts any in-flight instruction
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= ST_IDLE;
         pc_q       <= RESET_PC;
         ir_q       <= '0;
         reg_a_q    <= '0;
         reg_b_q    <= '0;
         reg_c_q    <= '0;
         reg_d_q    <= '0;
         carry_q    <= 1'b0;
         prog_req_q <= 1'b0;
         busy_q     <= 1'b0;
         halted_q   <= 1'b0;
      end else begin
         state_q    <= state_d;
         pc_q       <= pc_d;
         ir_q       <= ir_d;
         reg_a_q    <= reg_a_d;
         reg_b_q    <= reg_b_d;
         reg_c_q    <= reg_c_d;
         reg_d_q    <= reg_d_d;
         carry_q    <= carry_d;
         prog_req_q <= prog_req_d;
         busy_q     <= busy_d;
         halted_q   <= halted_d;
      end
   end

   assign prog_req  = prog_req_q;
   assign prog_addr = pc_q;
   assign busy      = busy_q;
   assign halted    = halted_q;
   assign reg_a     = reg_a_q;
   assign reg_b     = reg_b_q;
   assign reg_c     = reg_c_q;
   assign reg_d     = reg_d_q;
   assign carry     = carry_q;
   assign pc        = pc_q;

endmodule

// File: tb/tb_cpu_seq.sv
// tb/tb_cpu_seq.sv - directed self-checking bench for cpu_seq
module tb_cpu_seq;

   logic       clk = 1'b0;
   logic       rst_n = 1'b1;
   logic       start = 1'b0;
   logic       prog_ack = 1'b0;
   logic [7:0] prog_data;
   logic       prog_req, busy, halted, carry;
   logic [7:0] prog_addr, reg_a, reg_b, reg_c, reg_d, pc;

   int checks = 0;
   int failures = 0;
   int ack_delay = 0;
   bit spurious = 1'b0;
   int wait_cnt = 0;
   int cyc, unst;

   logic [7:0] mem [0:255];

   cpu_seq #(.RESET_PC(8'h00)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .start     (start),
      .prog_req  (prog_req),
      .prog_addr (prog_addr),
      .prog_ack  (prog_ack),
      .prog_data (prog_data),
      .busy      (busy),
      .halted    (halted),
      .reg_a     (reg_a),
      .reg_b     (reg_b),
      .reg_c     (reg_c),
      .reg_d     (reg_d),
      .carry     (carry),
      .pc        (pc)
   );

   always #5 clk = ~clk;

   assign prog_data = mem[prog_addr];

   // Program memory responder: ack after ack_delay wait cycles; optional stray acks when idle
   always @(negedge clk) begin
      if (!prog_req) begin
         prog_ack = spurious;
         wait_cnt = 0;
      end else if (wait_cnt >= ack_delay) begin
         prog_ack = 1'b1;
         wait_cnt = 0;
      end else begin
         prog_ack = 1'b0;
         wait_cnt++;
      end
   end

   task automatic fill(input logic [7:0] v);
      for (int i = 0; i < 256; i++) mem[i] = v;
   endtask

   task automatic load_prog1;
      fill(8'hF0);
      mem[0] = 8'h10; mem[1] = 8'd101;
      mem[2] = 8'h11; mem[3] = 8'd58;
      mem[4] = 8'hF0;
   endtask

   task automatic pulse_start;
      @(posedge clk); #1 start = 1'b1;
      @(posedge clk); #1 start = 1'b0;
   endtask

   // Counts clock edges until halted; also counts fetches that changed or dropped before ack
   task automatic wait_halted(input int mid_start, output int cycles, output int unstable);
      logic       req0;
      logic [7:0] addr0;
      cycles = 0;
      unstable = 0;
      while (!halted && cycles < 2000) begin
         req0  = prog_req;
         addr0 = prog_addr;
         if (mid_start != 0 && cycles == mid_start) start = 1'b1;
         @(posedge clk); #1;
         start = 1'b0;
         cycles++;
         if (req0 && !prog_ack && (!prog_req || prog_addr !== addr0)) unstable++;
      end
   endtask

   task automatic test_reset;
      #3 rst_n = 1'b0;
      #1;
      checks++; if (pc !== 8'h00) begin failures++; $display("FAIL reset_pc got=%0h exp=0", pc); end
      checks++; if (prog_addr !== 8'h00) begin failures++; $display("FAIL reset_prog_addr got=%0h exp=0", prog_addr); end
      checks++; if (prog_req !== 1'b0) begin failures++; $display("FAIL reset_prog_req got=%b exp=0", prog_req); end
      checks++; if (busy !== 1'b0 || halted !== 1'b0) begin failures++; $display("FAIL reset_status got busy=%b halted=%b exp 0/0", busy, halted); end
      checks++; if ({reg_a, reg_b, reg_c, reg_d} !== 32'h0) begin failures++; $display("FAIL reset_regs got=%h exp=0", {reg_a, reg_b, reg_c, reg_d}); end
      checks++; if (carry !== 1'b0) begin failures++; $display("FAIL reset_carry got=%b exp=0", carry); end
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      checks++; if (busy !== 1'b0 || prog_req !== 1'b0) begin failures++; $display("FAIL idle_without_start got busy=%b req=%b exp 0/0", busy, prog_req); end
   endtask

   task automatic test_ldi_halt;
      load_prog1();
      ack_delay = 0;
      pulse_start();
      wait_halted(0, cyc, unst);
      // LDI(3) + LDI(3) + HALT fetch/exec(2)
      checks++; if (cyc !== 8) begin failures++; $display("FAIL ldi_cycles got=%0d exp=8", cyc); end
      checks++; if (halted !== 1'b1 || busy !== 1'b0) begin failures++; $display("FAIL ldi_halted got halted=%b busy=%b exp 1/0", halted, busy); end
      checks++; if (reg_a !== 8'd101 || reg_b !== 8'd58) begin failures++; $display("FAIL ldi_regs got a=%0d b=%0d exp 101/58", reg_a, reg_b); end
      checks++; if (pc !== 8'd5) begin failures++; $display("FAIL ldi_pc got=%0d exp=5", pc); end
   endtask

   task automatic test_spurious_ack;
      spurious = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      checks++; if (halted !== 1'b1 || pc !== 8'd5) begin failures++; $display("FAIL spur_halted got halted=%b pc=%0d exp 1/5", halted, pc); end
      pulse_start();
      wait_halted(0, cyc, unst);
      checks++; if (cyc !== 8 || pc !== 8'd5) begin failures++; $display("FAIL spur_run got cycles=%0d pc=%0d exp 8/5", cyc, pc); end
      spurious = 1'b0;
   endtask

   task automatic test_exec;
      fill(8'hF0);
      mem[0] = 8'h10; mem[1] = 8'd101;
      mem[2] = 8'h11; mem[3] = 8'd58;
      mem[4] = 8'h12; mem[5] = 8'd83;
      mem[6] = 8'h13; mem[7] = 8'd87;
      mem[8] = 8'h00; mem[9] = 8'hF0;
      pulse_start();
      wait_halted(0, cyc, unst);
      // 101 + 58 + 0 = 159, no carry out
      checks++; if ({reg_a, reg_b, reg_c, reg_d} !== {8'd159, 8'd58, 8'd83, 8'd87}) begin failures++; $display("FAIL exec_regs got=%h exp=%h", {reg_a, reg_b, reg_c, reg_d}, {8'd159, 8'd58, 8'd83, 8'd87}); end
      checks++; if (carry !== 1'b0 || pc !== 8'd10 || cyc !== 16) begin failures++; $display("FAIL exec_misc got carry=%b pc=%0d cycles=%0d exp 0/10/16", carry, pc, cyc); end
      // 200 + 100 = 300 -> A=44, carry=1; C/D untouched across restart
      fill(8'hF0);
      mem[0] = 8'h10; mem[1] = 8'd200;
      mem[2] = 8'h11; mem[3] = 8'd100;
      mem[4] = 8'h00; mem[5] = 8'hF0;
      pulse_start();
      wait_halted(0, cyc, unst);
      checks++; if ({reg_a, reg_b, reg_c, reg_d} !== {8'd44, 8'd100, 8'd83, 8'd87}) begin failures++; $display("FAIL exec_ovf_regs got=%h exp=%h", {reg_a, reg_b, reg_c, reg_d}, {8'd44, 8'd100, 8'd83, 8'd87}); end
      checks++; if (carry !== 1'b1) begin failures++; $display("FAIL exec_ovf_carry got=%b exp=1", carry); end
      // LDI leaves carry=1, so 1 + 2 + 1 = 4 and carry clears
      fill(8'hF0);
      mem[0] = 8'h10; mem[1] = 8'd1;
      mem[2] = 8'h11; mem[3] = 8'd2;
      mem[4] = 8'h00; mem[5] = 8'hF0;
      pulse_start();
      wait_halted(0, cyc, unst);
      checks++; if (reg_a !== 8'd4 || carry !== 1'b0) begin failures++; $display("FAIL exec_carryin got a=%0d carry=%b exp 4/0", reg_a, carry); end
   endtask

   task automatic test_wait_states;
      load_prog1();
      ack_delay = 3;
      pulse_start();
      wait_halted(0, cyc, unst);
      // zero-wait 8 cycles + 5 fetches x 3 wait cycles
      checks++; if (cyc !== 23) begin failures++; $display("FAIL wait_cycles got=%0d exp=23", cyc); end
      checks++; if (unst !== 0) begin failures++; $display("FAIL wait_req_stable got=%0d exp=0", unst); end
      checks++; if (reg_a !== 8'd101 || reg_b !== 8'd58 || pc !== 8'd5 || halted !== 1'b1) begin failures++; $display("FAIL wait_final got a=%0d b=%0d pc=%0d halted=%b exp 101/58/5/1", reg_a, reg_b, pc, halted); end
   endtask

   task automatic test_back_to_back_start;
      load_prog1();
      ack_delay = 3;
      pulse_start();
      wait_halted(6, cyc, unst);
      checks++; if (cyc !== 23 || pc !== 8'd5) begin failures++; $display("FAIL busy_start got cycles=%0d pc=%0d exp 23/5", cyc, pc); end
      ack_delay = 0;
      pulse_start();
      checks++; if (busy !== 1'b1 || halted !== 1'b0 || pc !== 8'd0) begin failures++; $display("FAIL restart_state got busy=%b halted=%b pc=%0d exp 1/0/0", busy, halted, pc); end
      checks++; if (reg_a !== 8'd101 || reg_b !== 8'd58 || reg_c !== 8'd83) begin failures++; $display("FAIL restart_regs got a=%0d b=%0d c=%0d exp 101/58/83", reg_a, reg_b, reg_c); end
      wait_halted(0, cyc, unst);
      checks++; if (cyc !== 8 || halted !== 1'b1) begin failures++; $display("FAIL restart_run got cycles=%0d halted=%b exp 8/1", cyc, halted); end
   endtask

   task automatic test_pc_wrap;
      fill(8'h50);
      ack_delay = 0;
      pulse_start();
      @(posedge clk); #1;
      mem[0] = 8'hF0;
      wait_halted(0, cyc, unst);
      // rest of NOP@0 (1) + NOPs 1..255 (510) + HALT@0 (2)
      checks++; if (cyc !== 513) begin failures++; $display("FAIL wrap_cycles got=%0d exp=513", cyc); end
      checks++; if (halted !== 1'b1 || pc !== 8'd1) begin failures++; $display("FAIL wrap_halt got halted=%b pc=%0d exp 1/1", halted, pc); end
      checks++; if (reg_a !== 8'd101 || reg_d !== 8'd87) begin failures++; $display("FAIL wrap_regs got a=%0d d=%0d exp 101/87", reg_a, reg_d); end
   endtask

   task automatic test_reset_mid_fetch_imm;
      int n;
      fill(8'hF0);
      mem[0] = 8'h10; mem[1] = 8'h55;
      ack_delay = 2;
      pulse_start();
      n = 0;
      while (!(prog_req && pc == 8'd1) && n < 20) begin
         @(posedge clk); #1;
         n++;
      end
      checks++; if (n >= 20) begin failures++; $display("FAIL reach_fetch_imm got timeout exp pc=1 fetch"); end
      #2 rst_n = 1'b0;
      #1;
      checks++; if (busy !== 1'b0 || prog_req !== 1'b0 || halted !== 1'b0) begin failures++; $display("FAIL midrst_status got busy=%b req=%b halted=%b exp 0/0/0", busy, prog_req, halted); end
      checks++; if (pc !== 8'd0 || prog_addr !== 8'd0) begin failures++; $display("FAIL midrst_pc got pc=%0d addr=%0d exp 0/0", pc, prog_addr); end
      checks++; if (reg_a !== 8'd0 || reg_b !== 8'd0 || carry !== 1'b0) begin failures++; $display("FAIL midrst_regs got a=%0d b=%0d carry=%b exp 0/0/0", reg_a, reg_b, carry); end
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      checks++; if (busy !== 1'b0 || reg_a !== 8'd0) begin failures++; $display("FAIL midrst_idle got busy=%b a=%0d exp 0/0", busy, reg_a); end
      load_prog1();
      ack_delay = 0;
      pulse_start();
      wait_halted(0, cyc, unst);
      checks++; if (cyc !== 8 || reg_a !== 8'd101 || pc !== 8'd5) begin failures++; $display("FAIL midrst_rerun got cycles=%0d a=%0d pc=%0d exp 8/101/5", cyc, reg_a, pc); end
   endtask

   initial begin
      fill(8'hF0);
      test_reset();
      test_ldi_halt();
      test_spurious_ack();
      test_exec();
      test_wait_states();
      test_back_to_back_start();
      test_pc_wrap();
      test_reset_mid_fetch_imm();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
